// File: rtl/svm_scheduler_top.sv
// Conflict-filtering transaction batcher: input FIFO, read/write dependency
// accumulators for the open batch, and a grouped multi-lane batch dispatcher.
module svm_scheduler_top #(
  parameter int NUM_PARALLEL_INSTANCES   = 4,
  parameter int MAX_DEPENDENCIES         = 256,
  parameter int MAX_BATCH_SIZE           = 8,
  parameter int BATCH_TIMEOUT_CYCLES     = 100,
  parameter int MAX_PENDING_TRANSACTIONS = 16,
  parameter int INSERTION_QUEUE_DEPTH    = 8
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   s_axis_tvalid,
  output logic                                                   s_axis_tready,
  input  logic [63:0]                                            s_axis_tdata_owner_programID,
  input  logic [MAX_DEPENDENCIES-1:0]                            s_axis_tdata_read_dependencies,
  input  logic [MAX_DEPENDENCIES-1:0]                            s_axis_tdata_write_dependencies,
  output logic [NUM_PARALLEL_INSTANCES-1:0]                      m_axis_tvalid,
  input  logic [NUM_PARALLEL_INSTANCES-1:0]                      m_axis_tready,
  output logic [NUM_PARALLEL_INSTANCES-1:0][63:0]                m_axis_tdata_owner_programID,
  output logic [NUM_PARALLEL_INSTANCES-1:0][MAX_DEPENDENCIES-1:0] m_axis_tdata_read_dependencies,
  output logic [NUM_PARALLEL_INSTANCES-1:0][MAX_DEPENDENCIES-1:0] m_axis_tdata_write_dependencies,
  output logic [31:0]                                            total_raw_conflicts,
  output logic [31:0]                                            total_waw_conflicts,
  output logic [31:0]                                            total_war_conflicts,
  output logic [31:0]                                            total_filter_hits,
  output logic [31:0]                                            total_queue_occupancy,
  output logic [31:0]                                            total_current_batch_size,
  output logic [NUM_PARALLEL_INSTANCES-1:0]                      batch_completed
);

  localparam int N   = NUM_PARALLEL_INSTANCES;
  localparam int D   = MAX_DEPENDENCIES;
  localparam int QW  = $clog2(INSERTION_QUEUE_DEPTH);
  localparam int QCW = $clog2(INSERTION_QUEUE_DEPTH + 1);
  localparam int EW  = (MAX_BATCH_SIZE > 1) ? $clog2(MAX_BATCH_SIZE) : 1;
  localparam int CW  = $clog2(MAX_BATCH_SIZE + 1);
  localparam int TW  = (BATCH_TIMEOUT_CYCLES > 1) ? $clog2(BATCH_TIMEOUT_CYCLES) : 1;

  typedef enum logic {S_COLLECT = 1'b0, S_DRAIN = 1'b1} state_t;

  generate
    if (MAX_PENDING_TRANSACTIONS < MAX_BATCH_SIZE) begin : g_cfg_err
      $error("MAX_PENDING_TRANSACTIONS must be >= MAX_BATCH_SIZE");
    end
  endgenerate

  state_t          r_state, w_state_next;
  logic [63:0]     r_q_id [INSERTION_QUEUE_DEPTH];
  logic [D-1:0]    r_q_rd [INSERTION_QUEUE_DEPTH];
  logic [D-1:0]    r_q_wr [INSERTION_QUEUE_DEPTH];
  logic [QW-1:0]   r_q_wptr, r_q_rptr;
  logic [QCW-1:0]  r_q_cnt;
  logic [63:0]     r_ent_id [MAX_BATCH_SIZE];
  logic [D-1:0]    r_ent_rd [MAX_BATCH_SIZE];
  logic [D-1:0]    r_ent_wr [MAX_BATCH_SIZE];
  logic [D-1:0]    r_racc, r_wacc;
  logic [CW-1:0]   r_count, r_base;
  logic [TW-1:0]   r_timer;
  logic [N-1:0]    r_done;
  logic [31:0]     r_raw_cnt, r_waw_cnt, r_war_cnt, r_hit_cnt;

  logic            w_push, w_pop, w_close, w_grp_fire, w_last_grp;
  logic            w_raw, w_waw, w_war, w_conflict;
  logic [63:0]     w_head_id;
  logic [D-1:0]    w_head_rd, w_head_wr;
  logic [N-1:0]    w_lane_valid, w_lane_used;

  // Input FIFO: first-word-fall-through so the head can be conflict-checked in the pop cycle
  assign s_axis_tready = rst_n && (r_q_cnt != QCW'(INSERTION_QUEUE_DEPTH));
  assign w_push        = s_axis_tvalid && s_axis_tready;
  assign w_head_id     = r_q_id[r_q_rptr];
  assign w_head_rd     = r_q_rd[r_q_rptr];
  assign w_head_wr     = r_q_wr[r_q_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_id[r_q_wptr] <= s_axis_tdata_owner_programID;
      r_q_rd[r_q_wptr] <= s_axis_tdata_read_dependencies;
      r_q_wr[r_q_wptr] <= s_axis_tdata_write_dependencies;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q_wptr <= '0;
      r_q_rptr <= '0;
      r_q_cnt  <= '0;
    end else begin
      if (w_push) r_q_wptr <= r_q_wptr + QW'(1);
      if (w_pop)  r_q_rptr <= r_q_rptr + QW'(1);
      case ({w_push, w_pop})
        2'b10:   r_q_cnt <= r_q_cnt + QCW'(1);
        2'b01:   r_q_cnt <= r_q_cnt - QCW'(1);
        default: r_q_cnt <= r_q_cnt;
      endcase
    end
  end

  assign w_raw      = |(w_head_rd & r_wacc);
  assign w_waw      = |(w_head_wr & r_wacc);
  assign w_war      = |(w_head_wr & r_racc);
  assign w_conflict = w_raw || w_waw || w_war;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_COLLECT;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_close      = 1'b0;
    w_pop        = 1'b0;
    w_grp_fire   = 1'b0;
    w_last_grp   = 1'b0;
    case (r_state)
      S_COLLECT: begin
        w_close = (r_count == CW'(MAX_BATCH_SIZE)) ||
                  ((r_count != '0) && (r_timer == TW'(BATCH_TIMEOUT_CYCLES - 1)));
        if (w_close) w_state_next = S_DRAIN;
        else         w_pop = (r_q_cnt != '0);
      end
      S_DRAIN: begin
        w_grp_fire = &(~w_lane_valid | m_axis_tready);
        w_last_grp = w_grp_fire && ((32'(r_base) + N) >= 32'(r_count));
        if (w_last_grp) w_state_next = S_COLLECT;
      end
      default: w_state_next = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_pop && !w_conflict) begin
      r_ent_id[r_count[EW-1:0]] <= w_head_id;
      r_ent_rd[r_count[EW-1:0]] <= w_head_rd;
      r_ent_wr[r_count[EW-1:0]] <= w_head_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_base    <= '0;
      r_timer   <= '0;
      r_racc    <= '0;
      r_wacc    <= '0;
      r_done    <= '0;
      r_raw_cnt <= '0;
      r_waw_cnt <= '0;
      r_war_cnt <= '0;
      r_hit_cnt <= '0;
    end else begin
      r_done <= '0;
      if (w_close) begin
        r_timer <= '0;
        r_base  <= '0;
      end else if (r_state == S_COLLECT) begin
        r_timer <= (r_count != '0) ? r_timer + TW'(1) : '0;
      end
      if (w_pop) begin
        if (w_conflict) begin
          r_raw_cnt <= r_raw_cnt + 32'(w_raw);
          r_waw_cnt <= r_waw_cnt + 32'(w_waw);
          r_war_cnt <= r_war_cnt + 32'(w_war);
          r_hit_cnt <= r_hit_cnt + 32'd1;
        end else begin
          r_count <= r_count + CW'(1);
          r_racc  <= r_racc | w_head_rd;
          r_wacc  <= r_wacc | w_head_wr;
        end
      end
      if (w_grp_fire) begin
        if (w_last_grp) begin
          r_count <= '0;
          r_base  <= '0;
          r_timer <= '0;
          r_racc  <= '0;
          r_wacc  <= '0;
          r_done  <= w_lane_used;
        end else begin
          r_base <= r_base + CW'(N);
        end
      end
    end
  end

  // Lane k shows entry base+k; invalid lanes are forced to zero
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [31:0]   w_idx;
      logic [EW-1:0] w_sel;
      assign w_idx            = 32'(r_base) + gi;
      assign w_sel            = w_idx[EW-1:0];
      assign w_lane_valid[gi] = (r_state == S_DRAIN) && (w_idx < 32'(r_count));
      assign w_lane_used[gi]  = (32'(gi) < 32'(r_count));
      assign m_axis_tdata_owner_programID[gi]    = w_lane_valid[gi] ? r_ent_id[w_sel] : '0;
      assign m_axis_tdata_read_dependencies[gi]  = w_lane_valid[gi] ? r_ent_rd[w_sel] : '0;
      assign m_axis_tdata_write_dependencies[gi] = w_lane_valid[gi] ? r_ent_wr[w_sel] : '0;
    end
  endgenerate

  assign m_axis_tvalid            = w_lane_valid;
  assign batch_completed          = r_done;
  assign total_raw_conflicts      = r_raw_cnt;
  assign total_waw_conflicts      = r_waw_cnt;
  assign total_war_conflicts      = r_war_cnt;
  assign total_filter_hits        = r_hit_cnt;
  assign total_queue_occupancy    = 32'(r_q_cnt);
  assign total_current_batch_size = 32'(r_count);

endmodule

// File: tb/tb_svm_scheduler_top.sv
// Self-checking bench for svm_scheduler_top: conflict table, directed batch
// sequences, and a randomized stream checked against a batch-forming model.
module tb_svm_scheduler_top;
  localparam int N  = 4;
  localparam int D  = 256;
  localparam int MB = 8;
  localparam int NR = 48;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  s_axis_tvalid, s_axis_tready;
  logic [63:0]           s_id;
  logic [D-1:0]          s_rd, s_wr;
  logic [N-1:0]          m_axis_tvalid, m_axis_tready;
  logic [N-1:0][63:0]    m_id;
  logic [N-1:0][D-1:0]   m_rd, m_wr;
  logic [31:0]           raw_c, waw_c, war_c, hit_c, occ, bsize;
  logic [N-1:0]          batch_completed;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  svm_scheduler_top dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata_owner_programID(s_id),
    .s_axis_tdata_read_dependencies(s_rd),
    .s_axis_tdata_write_dependencies(s_wr),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata_owner_programID(m_id),
    .m_axis_tdata_read_dependencies(m_rd),
    .m_axis_tdata_write_dependencies(m_wr),
    .total_raw_conflicts(raw_c), .total_waw_conflicts(waw_c),
    .total_war_conflicts(war_c), .total_filter_hits(hit_c),
    .total_queue_occupancy(occ), .total_current_batch_size(bsize),
    .batch_completed(batch_completed)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [63:0] id, input logic [D-1:0] r, input logic [D-1:0] w);
    int t;
    t = 0;
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_id = id;
    s_rd = r;
    s_wr = w;
    while (!s_axis_tready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("push_ready", 256'(s_axis_tready), 256'(1));
    @(posedge clk);
    #1 s_axis_tvalid = 1'b0;
    $display("push id=%0h r=%0h w=%0h", id, r, w);
  endtask

  task automatic wait_valid(input int max, output int lat);
    lat = 0;
    while (m_axis_tvalid == '0 && lat < max) begin
      @(negedge clk);
      lat++;
    end
    if (m_axis_tvalid == '0) check("wait_valid", 256'(m_axis_tvalid != '0), 256'(1));
  endtask

  typedef struct {
    logic [D-1:0] ra, wa, rb, wb;
    logic [31:0]  raw, waw, war, hit, size;
  } vec_t;

  logic [63:0]  tx_id [NR];
  logic [D-1:0] tx_r  [NR];
  logic [D-1:0] tx_w  [NR];
  int           exp_q[$];
  int           sizes[$];
  logic [31:0]  m_raw, m_waw, m_war, m_hit;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tbl [7];
    int           lat;
    logic [D-1:0] one;
    one = 1;
    tbl[0] = '{256'h0,  256'h1,  256'h1,    256'h0,        32'd1, 32'd0, 32'd0, 32'd1, 32'd1};
    tbl[1] = '{256'h2,  256'h0,  256'h0,    256'h2,        32'd0, 32'd0, 32'd1, 32'd1, 32'd1};
    tbl[2] = '{256'h0,  256'h4,  256'h0,    256'h4,        32'd0, 32'd1, 32'd0, 32'd1, 32'd1};
    tbl[3] = '{256'h0,  256'h8,  256'h8,    256'h8,        32'd1, 32'd1, 32'd0, 32'd1, 32'd1};
    tbl[4] = '{256'h10, 256'h20, 256'h20,   256'h30,       32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
    tbl[5] = '{256'hF0, 256'h0,  256'hF0,   256'h0,        32'd0, 32'd0, 32'd0, 32'd0, 32'd2};
    tbl[6] = '{256'h0,  256'hFF, 256'hFF00, 256'hFF000000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd2};

    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    s_id = '0;
    s_rd = '0;
    s_wr = '0;
    m_axis_tready = '0;
    repeat (3) @(negedge clk);
    check("rst_tready", 256'(s_axis_tready), 256'(0));
    check("rst_tvalid", 256'(m_axis_tvalid), 256'(0));
    check("rst_counters", 256'({raw_c, waw_c, war_c, hit_c, occ, bsize}), 256'(0));
    check("rst_done", 256'(batch_completed), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("tready_after_rst", 256'(s_axis_tready), 256'(1));

    // single transaction closed by timeout
    push(64'd0, '0, 256'hFF);
    wait_valid(300, lat);
    check("timeout_window", 256'(lat >= 100 && lat <= 104), 256'(1));
    check("single_valid", 256'(m_axis_tvalid), 256'(4'b0001));
    check("single_id", 256'(m_id[0]), 256'(0));
    check("single_w", m_wr[0], 256'hFF);
    check("idle_lane_zero", m_wr[1], 256'h0);
    m_axis_tready = 4'b0001;
    @(negedge clk);
    check("single_done", 256'(batch_completed), 256'(4'b0001));
    check("single_valid_off", 256'(m_axis_tvalid), 256'(0));
    @(negedge clk);
    check("single_done_pulse", 256'(batch_completed), 256'(0));
    check("single_conflicts", 256'({raw_c, waw_c, war_c, hit_c}), 256'(0));

    // conflict table
    for (int i = 0; i < 7; i++) begin
      do_reset();
      push(64'd10, tbl[i].ra, tbl[i].wa);
      push(64'd11, tbl[i].rb, tbl[i].wb);
      repeat (3) @(negedge clk);
      check($sformatf("tbl%0d_raw", i), 256'(raw_c), 256'(tbl[i].raw));
      check($sformatf("tbl%0d_waw", i), 256'(waw_c), 256'(tbl[i].waw));
      check($sformatf("tbl%0d_war", i), 256'(war_c), 256'(tbl[i].war));
      check($sformatf("tbl%0d_hit", i), 256'(hit_c), 256'(tbl[i].hit));
      check($sformatf("tbl%0d_size", i), 256'(bsize), 256'(tbl[i].size));
    end

    // IDs 0,1,2 with ID2 rejected for WAW, batch of two dispatched
    do_reset();
    m_axis_tready = '1;
    push(64'd0, '0, 256'hFF);
    push(64'd1, 256'hFF00, 256'hFF000000);
    push(64'd2, 256'hFF00, 256'hFF000000);
    repeat (3) @(negedge clk);
    check("seq2_counts", 256'({raw_c, waw_c, war_c, hit_c}), 256'({32'd0, 32'd1, 32'd0, 32'd1}));
    wait_valid(300, lat);
    check("seq2_valid", 256'(m_axis_tvalid), 256'(4'b0011));
    check("seq2_ids", 256'({m_id[1], m_id[0]}), 256'({64'd1, 64'd0}));
    @(negedge clk);
    check("seq2_done", 256'(batch_completed), 256'(4'b0011));

    // full batch of 8, lane 2 stalls, FIFO fills behind it
    do_reset();
    m_axis_tready = 4'b1011;
    for (int i = 0; i < 8; i++) push(64'(i), '0, one << i);
    wait_valid(50, lat);
    check("full_close_fast", 256'(lat < 20), 256'(1));
    check("grp0_valid", 256'(m_axis_tvalid), 256'(4'b1111));
    for (int k = 0; k < N; k++) check($sformatf("grp0_id%0d", k), 256'(m_id[k]), 256'(k));
    for (int i = 0; i < 8; i++) push(64'(100 + i), '0, one << (i + 8));
    @(negedge clk);
    check("fifo_full_tready", 256'(s_axis_tready), 256'(0));
    check("fifo_full_occ", 256'(occ), 256'(8));
    check("stall_size", 256'(bsize), 256'(8));
    check("stall_valid", 256'(m_axis_tvalid), 256'(4'b1111));
    for (int k = 0; k < N; k++) check($sformatf("stall_id%0d", k), 256'(m_id[k]), 256'(k));
    m_axis_tready = 4'b1111;
    @(negedge clk);
    for (int k = 0; k < N; k++) check($sformatf("grp1_id%0d", k), 256'(m_id[k]), 256'(4 + k));
    check("grp1_no_done", 256'(batch_completed), 256'(0));
    @(negedge clk);
    check("full_done", 256'(batch_completed), 256'(4'b1111));
    check("full_valid_off", 256'(m_axis_tvalid), 256'(0));
    m_axis_tready = '0;
    wait_valid(50, lat);
    check("batch2_id0", 256'(m_id[0]), 256'(100));
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", 256'(m_axis_tvalid), 256'(0));
    check("midrst_size", 256'(bsize), 256'(0));
    check("midrst_occ", 256'(occ), 256'(0));
    check("midrst_tready", 256'(s_axis_tready), 256'(0));
    rst_n = 1'b1;

    // randomized stream against the batch-forming model
    for (int i = 0; i < NR; i++) begin
      tx_id[i] = {$urandom, 32'(i)};
      tx_r[i]  = ($urandom_range(0, 3) == 0) ? '0 : (one << $urandom_range(0, 47));
      tx_w[i]  = ($urandom_range(0, 3) == 0) ? '0 : (one << $urandom_range(0, 47));
    end
    begin
      logic [D-1:0] acc_r, acc_w;
      int           cnt;
      logic         f_raw, f_waw, f_war;
      acc_r = '0; acc_w = '0; cnt = 0;
      m_raw = 0; m_waw = 0; m_war = 0; m_hit = 0;
      for (int i = 0; i < NR; i++) begin
        f_raw = |(tx_r[i] & acc_w);
        f_waw = |(tx_w[i] & acc_w);
        f_war = |(tx_w[i] & acc_r);
        if (f_raw || f_waw || f_war) begin
          m_raw += 32'(f_raw);
          m_waw += 32'(f_waw);
          m_war += 32'(f_war);
          m_hit += 1;
        end else begin
          exp_q.push_back(i);
          cnt++;
          acc_r |= tx_r[i];
          acc_w |= tx_w[i];
          if (cnt == MB) begin
            sizes.push_back(cnt);
            cnt = 0; acc_r = '0; acc_w = '0;
          end
        end
      end
      if (cnt > 0) sizes.push_back(cnt);
    end
    do_reset();
    fork
      begin : drv
        int i;
        int dc;
        i = 0;
        dc = 0;
        while (i < NR && dc < 20000) begin
          @(negedge clk);
          dc++;
          if ($urandom_range(0, 3) == 0) s_axis_tvalid = 1'b0;
          else begin
            s_axis_tvalid = 1'b1;
            s_id = tx_id[i];
            s_rd = tx_r[i];
            s_wr = tx_w[i];
            if (s_axis_tready) i++;
          end
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
      end
      begin : sink
        int           rx, bi, cyc, cum;
        logic         stall_prev, fire;
        logic [N-1:0] pv;
        logic [63:0]  pid [N];
        logic [N-1:0] emask;
        rx = 0; bi = 0; cyc = 0; cum = 0;
        stall_prev = 1'b0;
        pv = '0;
        while ((rx < exp_q.size() || bi < sizes.size()) && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          m_axis_tready = ($urandom_range(0, 1) == 0) ? '1 : N'($urandom_range(0, 15));
          if (stall_prev) begin
            check("rnd_stall_valid", 256'(m_axis_tvalid), 256'(pv));
            for (int k = 0; k < N; k++)
              if (pv[k]) check("rnd_stall_id", 256'(m_id[k]), 256'(pid[k]));
          end
          if (batch_completed != '0) begin
            if (bi < sizes.size()) begin
              emask = (sizes[bi] >= N) ? '1 : N'((1 << sizes[bi]) - 1);
              check("rnd_batch_mask", 256'(batch_completed), 256'(emask));
              cum += sizes[bi];
              check("rnd_batch_boundary", 256'(rx), 256'(cum));
            end else begin
              check("rnd_extra_batch", 256'(batch_completed), 256'(0));
            end
            bi++;
          end
          fire = (m_axis_tvalid != '0) && ((~m_axis_tvalid | m_axis_tready) == '1);
          if (fire) begin
            for (int k = 0; k < N; k++) begin
              if (m_axis_tvalid[k]) begin
                if (rx < exp_q.size()) begin
                  check("rnd_id", 256'(m_id[k]), 256'(tx_id[exp_q[rx]]));
                  check("rnd_r", m_rd[k], tx_r[exp_q[rx]]);
                  check("rnd_w", m_wr[k], tx_w[exp_q[rx]]);
                  $display("dispatch lane=%0d id=%0h", k, m_id[k]);
                end else begin
                  check("rnd_extra_dispatch", 256'(m_axis_tvalid), 256'(0));
                end
                rx++;
              end
            end
          end
          stall_prev = (m_axis_tvalid != '0) && !fire;
          pv = m_axis_tvalid;
          for (int k = 0; k < N; k++) pid[k] = m_id[k];
        end
        if (rx < exp_q.size() || bi < sizes.size())
          check("rnd_drain_budget", 256'(rx), 256'(exp_q.size()));
      end
    join
    @(negedge clk);
    check("rnd_raw", 256'(raw_c), 256'(m_raw));
    check("rnd_waw", 256'(waw_c), 256'(m_waw));
    check("rnd_war", 256'(war_c), 256'(m_war));
    check("rnd_hit", 256'(hit_c), 256'(m_hit));
    check("rnd_final_size", 256'(bsize), 256'(0));
    check("rnd_final_occ", 256'(occ), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
